// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin ties, lock-based ownership.
// Ports: req/we/lock/addr/wdata per requester in, gnt/rvalid/rdata out, mem_* to memory.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nx;
  // 1 means requester 1 was granted last, so 0 wins the next tie
  logic       last_gnt;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state)
        OWN0: gnt0 = req0;
        OWN1: gnt1 = req1;
        default: begin
          if (req0 && req1) begin
            gnt0 = last_gnt;
            gnt1 = !last_gnt;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
      endcase
    end
  end

  // ownership exits one cycle after lock drops
  always_comb begin
    state_nx = IDLE;
    case (state)
      OWN0: state_nx = lock0 ? OWN0 : IDLE;
      OWN1: state_nx = lock1 ? OWN1 : IDLE;
      default: begin
        if (gnt0 && lock0)
          state_nx = OWN0;
        else if (gnt1 && lock1)
          state_nx = OWN1;
        else
          state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      gnt0: begin
        mem_write = we0;
        mem_read  = !we0;
        mem_addr  = addr0;
        mem_wdata = wdata0;
      end
      gnt1: begin
        mem_write = we1;
        mem_read  = !we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state   <= state_nx;
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0)
        last_gnt <= 1'b0;
      else if (gnt1)
        last_gnt <= 1'b1;
    end
  end

  assign rdata0 = mem_rdata;
  assign rdata1 = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, word-address width; DATA_W, 32, data width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1  requester 0/1 access request.
REQ-005 we0 / we1  input  1  requester 0/1 access type: 1 = write, 0 = read.
REQ-006 lock0 / lock1  input  1  requester 0/1 holds ownership across cycles.
REQ-007 addr0 / addr1  input  ADDR_W  requester 0/1 word address.
REQ-008 wdata0 / wdata1  input  DATA_W  requester 0/1 write data.
REQ-009 gnt0 / gnt1  output  1  requester 0/1 access accepted this cycle (combinational).
REQ-010 rvalid0 / rvalid1  output  1  read data for requester 0/1 valid this cycle (registered).
REQ-011 rdata0 / rdata1  output  DATA_W  read data to requester 0/1; both equal mem_rdata.
REQ-012 mem_write / mem_read  output  1  write/read strobe to the data memory.
REQ-013 mem_addr / mem_wdata  output  ADDR_W / DATA_W  address/write data to the data memory.
REQ-014 mem_rdata  input  DATA_W  data memory read data, valid one cycle after mem_read.

Function
REQ-015 At most one of gnt0, gnt1 SHALL be 1 in any cycle; a request is accepted exactly in a cycle where its gnt is 1.
REQ-016 FSM states SHALL be IDLE, OWN0, OWN1; ownership only restricts which requester may be granted.
REQ-017 IDLE: single requester asserting req is granted; if req0 and req1, grant goes to the requester not recorded in last_gnt (round-robin).
REQ-018 OWNi: only requester i is granted, iff req_i=1; the other requester's req is ignored (no gnt).
REQ-019 Next state SHALL be OWNi when requester i is granted in IDLE with lock_i=1; OWNi persists while lock_i=1 (regardless of req_i) and returns to IDLE in the cycle after lock_i=0.
REQ-020 lock_i with no grant in IDLE SHALL have no effect.
REQ-021 last_gnt register SHALL update to i on every cycle gnt_i=1, including grants in OWNi.
REQ-022 On gnt_i: mem_write = we_i, mem_read = !we_i, mem_addr = addr_i, mem_wdata = wdata_i, all combinational same cycle.
REQ-023 With no grant: mem_write = mem_read = 0; mem_addr and mem_wdata are don't-care.
REQ-024 rvalid_i SHALL be 1 exactly one cycle after a cycle with gnt_i=1 and we_i=0; read latency = 1 cycle.
REQ-025 Back-to-back reads (any mix of requesters) SHALL be accepted every cycle, each rvalid pulse one cycle long, routed to the correct requester.
REQ-026 Write then read of same address in consecutive cycles SHALL return the new data (memory write-first ordering across cycles).
REQ-027 Requests held unaccepted SHALL be kept stable by the requester; the arbiter keeps no request queue.
REQ-028 No starvation in IDLE: with both requesting continuously and no lock, grants SHALL alternate 0,1,0,1...

Reset
REQ-029 While rst=1: state = IDLE, last_gnt = 1 (requester 0 wins first tie), rvalid0 = rvalid1 = 0, gnt0 = gnt1 = 0, mem_write = mem_read = 0.
REQ-030 rst asserted mid-operation SHALL abort ownership and drop any pending rvalid; first cycle after release behaves as IDLE.

Verification
REQ-031 Tie: after reset, req0=req1=1, we=0, addr0=0x10, addr1=0x20, 4 cycles -> gnt sequence 0,1,0,1; mem_addr 0x10,0x20,0x10,0x20; rvalid0/rvalid1 pulses alternate one cycle later.
REQ-032 Write/read: req1 write addr 0x05 data 0xDEADBEEF, next cycle req1 read addr 0x05 -> rvalid1=1 next cycle with rdata1=0xDEADBEEF, rvalid0 stays 0.
REQ-033 Lock: req0+lock0 for 3 cycles with req1=1 throughout -> gnt0 3 cycles, gnt1=0; lock0 drops -> gnt1=1 in the first cycle after OWN0 exits.
REQ-034 Lock idle hold: OWN1 with req1=0, lock1=1, req0=1 -> no grant, mem_read=mem_write=0 until lock1=0.
REQ-035 Reset mid-read: gnt0 read at cycle N, rst=1 asynchronously before edge N+1 -> rvalid0=0, gnt outputs 0, state IDLE, next tie goes to requester 0.
